// File: rtl/fifo_stage.sv
// -----------------------------------------------------------------------------
// fifo_stage
//
// Purpose:
//   Single elastic FIFO stage with a valid/ack handshake on both sides. It is
//   meant as a building block for chained FIFOs and pipelines. The stage holds
//   up to DEPTH words in a circular buffer and decouples upstream from
//   downstream.
//
//   ack_out is a register, so a downstream ack_in never reaches ack_out
//   through combinational logic. A word pushed on one edge can be popped
//   on the following edge at the earliest; data_in never bypasses storage.
//
// Parameters:
//   DATA_WIDTH  width of data_in / data_out (default 3)
//   DEPTH       number of storage entries, DEPTH >= 1 (default 2).
//               DEPTH >= 2 sustains one word per cycle.
//               DEPTH == 1 sustains one word every two cycles.
//
// Ports:
//   clk        in   1                  rising-edge clock
//   rst_n      in   1                  synchronous active-low reset
//   valid_in   in   1                  upstream presents data_in
//   data_in    in   DATA_WIDTH         upstream data
//   ack_out    out  1                  stage can accept a word (registered)
//   valid_out  out  1                  stage presents data_out
//   data_out   out  DATA_WIDTH         head-of-queue data
//   ack_in     in   1                  downstream accepts data_out
//   level      out  $clog2(DEPTH+1)    occupancy. Present only when the
//                                      STAGE_LEVEL_EN macro is defined.
//
// Optional feature macro: STAGE_LEVEL_EN
// -----------------------------------------------------------------------------
module fifo_stage #(
    parameter int DATA_WIDTH = 3,
    parameter int DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic                        ack_out,
    output logic                        valid_out,
    output logic [DATA_WIDTH-1:0]       data_out,
    input  logic                        ack_in
`ifdef STAGE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]  level
`endif
);

    // A single-entry buffer still needs a 1-bit pointer to keep the declarations legal.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    // Storage and state registers.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ack_out;

    // Combinational next-state values.
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count_next;
    logic                  w_ack_next;
    logic [PTR_W-1:0]      w_wr_ptr_next;
    logic [PTR_W-1:0]      w_rd_ptr_next;

    // Circular increment. The explicit wrap at DEPTH-1 is what makes
    // non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + ONE_PTR;
        end
        return nxt;
    endfunction

    // Handshake decode, occupancy update and the next value of the ack register.
    always_comb begin
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_count_next  = r_count;
        w_ack_next    = 1'b0;
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;

        // The registered ack gates the push, so a full stage ignores valid_in
        // even while a pop frees an entry on the same edge.
        w_push = valid_in & r_ack_out;
        // An empty stage ignores ack_in.
        w_pop  = (r_count != {CNT_W{1'b0}}) & ack_in;

        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + ONE_CNT;
            2'b01:   w_count_next = r_count - ONE_CNT;
            default: w_count_next = r_count;
        endcase

        if (w_push) begin
            w_wr_ptr_next = next_ptr(r_wr_ptr);
        end else begin
            w_wr_ptr_next = r_wr_ptr;
        end

        if (w_pop) begin
            w_rd_ptr_next = next_ptr(r_rd_ptr);
        end else begin
            w_rd_ptr_next = r_rd_ptr;
        end

        // ack_out is derived from state only, so there is no path from ack_in to ack_out.
        w_ack_next = (w_count_next < FULL_CNT);
    end

    // State registers. The synchronous reset clears everything, including the storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_ack_out <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            r_wr_ptr  <= w_wr_ptr_next;
            r_rd_ptr  <= w_rd_ptr_next;
            r_count   <= w_count_next;
            r_ack_out <= w_ack_next;
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_in;
            end
        end
    end

    // Outputs are decoded directly from registers. Nothing in data_in reaches data_out
    // in the same cycle.
    assign ack_out   = r_ack_out;
    assign valid_out = (r_count != {CNT_W{1'b0}});
    assign data_out  = r_mem[r_rd_ptr];

`ifdef STAGE_LEVEL_EN
    assign level = r_count;
`endif

endmodule

// File: tb/tb_fifo_stage.sv
// -----------------------------------------------------------------------------
// tb_fifo_stage
//
// Directed bench for fifo_stage (DATA_WIDTH=3, DEPTH=2).
//
// The stimulus process keeps a behavioural model of the stage: an occupancy
// count, the expected ack register and a queue of expected words. A monitor
// on the falling clock edge compares the DUT's presented outputs against the
// queue head and pops the queue whenever the DUT performs a pop transfer.
// -----------------------------------------------------------------------------
module tb_fifo_stage;

    localparam int DW    = 3;
    localparam int DEPTH = 2;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ack_out;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          ack_in;
`ifdef STAGE_LEVEL_EN
    logic [1:0]    level;
`endif

    fifo_stage #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ack_in    (ack_in)
`ifdef STAGE_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state and counters
    logic [DW-1:0] exp_q[$];
    int            m_count = 0;
    logic          m_ack   = 1'b0;
    int            checks  = 0;
    int            errors  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, then advance the model past the edge.
    task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic a);
        logic p_rst;
        logic p_push;
        logic p_pop;
        rst_n    = r;
        valid_in = v;
        data_in  = d;
        ack_in   = a;
        p_rst  = ~r;
        p_push = r & v & m_ack;
        p_pop  = r & a & (m_count != 0);
        @(posedge clk);
        #1;
        if (p_rst) begin
            m_count = 0;
            m_ack   = 1'b0;
            exp_q.delete();
        end else begin
            if (p_push) exp_q.push_back(d);
            m_count = m_count + int'(p_push) - int'(p_pop);
            m_ack   = (m_count < DEPTH);
        end
    endtask

    // Monitor: compare the presented outputs and consume the expected word on each pop.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("ack_out", int'(ack_out), int'(m_ack));
            chk("valid_out", int'(valid_out), int'(m_count != 0));
`ifdef STAGE_LEVEL_EN
            chk("level", int'(level), m_count);
`endif
            if (valid_out === 1'b1 && exp_q.size() != 0) begin
                chk("data_out", int'(data_out), int'(exp_q[0]));
                if (ack_in === 1'b1) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = 3'd0;
        ack_in   = 1'b0;

        // Reset with valid_in high: nothing may be stored.
        step(1'b0, 1'b1, 3'd5, 1'b0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_ack_out", int'(ack_out), 0);
        chk("rst_data_out", int'(data_out), 0);
`ifdef STAGE_LEVEL_EN
        chk("rst_level", int'(level), 0);
`endif
        // First edge after release: no push yet, ack_out rises.
        step(1'b1, 1'b1, 3'd1, 1'b0);
        chk("ack_rise", int'(ack_out), 1);
        chk("empty_after_release", int'(valid_out), 0);

        // Fill with 1 and 2 while downstream stalls.
        step(1'b1, 1'b1, 3'd1, 1'b0);
        step(1'b1, 1'b1, 3'd2, 1'b0);
        chk("full_valid_out", int'(valid_out), 1);
        chk("full_data_out", int'(data_out), 1);
        chk("full_ack_out", int'(ack_out), 0);
`ifdef STAGE_LEVEL_EN
        chk("full_level", int'(level), 2);
`endif
        // Data 3 held while full must not be accepted.
        step(1'b1, 1'b1, 3'd3, 1'b0);
        step(1'b1, 1'b1, 3'd3, 1'b0);
        chk("full_hold_data", int'(data_out), 1);

        // Drain while full: pop 1 with no push, then push 3 while popping 2.
        step(1'b1, 1'b1, 3'd3, 1'b1);
        chk("drain1_data", int'(data_out), 2);
        chk("drain1_ack", int'(ack_out), 1);
        step(1'b1, 1'b1, 3'd3, 1'b1);
        chk("drain2_data", int'(data_out), 3);

        // Empty: ack_in is ignored and data 4 never enters.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd4, 1'b1);
        chk("empty_valid_out", int'(valid_out), 0);
        chk("empty_ack_out", int'(ack_out), 1);

        // Streaming 0..7 with both sides ready.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i), 1'b1);
        chk("stream_valid", int'(valid_out), 1);
        chk("stream_last_data", int'(data_out), 7);
        step(1'b1, 1'b0, 3'd0, 1'b1);
        chk("stream_drained", int'(valid_out), 0);
        chk("stream_queue_empty", exp_q.size(), 0);

        // Reset mid-operation with two words stored.
        step(1'b1, 1'b1, 3'd6, 1'b0);
        step(1'b1, 1'b1, 3'd7, 1'b0);
        chk("pre_reset_valid", int'(valid_out), 1);
        chk("pre_reset_data", int'(data_out), 6);
        step(1'b0, 1'b0, 3'd0, 1'b0);
        chk("midrst_valid_out", int'(valid_out), 0);
        chk("midrst_data_out", int'(data_out), 0);
`ifdef STAGE_LEVEL_EN
        chk("midrst_level", int'(level), 0);
`endif
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, 1'b1);
        chk("post_rst_valid", int'(valid_out), 0);
        chk("post_rst_ack", int'(ack_out), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
